// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable instruction memory, PC, synchronous-read fetch and prefetch FIFO.
// Optional performance counters are compiled in with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int               XLEN       = 32,
  parameter int               DEPTH      = 64,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0]  RESET_PC   = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  input  logic                     start,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [XLEN-1:0]          instruction_word,
  output logic [XLEN-1:0]          instr_pc,
  output logic [XLEN-1:0]          Addition_result,
  output logic                     halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [15:0]              flush_count
`endif
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              FW         = $clog2(FIFO_DEPTH);
  localparam logic [XLEN-1:0] ECALL      = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            r_ecall_stop;
  logic            r_halted;
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [FW-1:0]   r_wptr;
  logic [FW-1:0]   r_rptr;
  logic [FW:0]     r_count;

  logic            w_in_fetch;
  logic            w_start;
  logic            w_mem_we;
  logic            w_valid;
  logic            w_redirect;
  logic            w_pop;
  logic            w_push;
  logic            w_push_ecall;
  logic            w_halt_go;
  logic            w_issue;
  logic [FW+1:0]   w_occ;
  logic [AW-1:0]   w_rd_idx;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_head_data;
  logic [XLEN-1:0] w_head_pc;

  assign w_in_fetch    = (r_state == S_FETCH);
  assign w_start       = start && ((r_state == S_IDLE) || (r_state == S_HALT));
  assign w_mem_we      = load_en && (r_state != S_FETCH);
  assign w_valid       = w_in_fetch && (r_count != {(FW+1){1'b0}});
  assign w_redirect    = w_in_fetch && redirect_valid;
  assign w_head_data   = r_fifo_data[r_rptr];
  assign w_head_pc     = r_fifo_pc[r_rptr];
  assign w_pop         = w_valid && instr_ready && !redirect_valid;
  assign w_push        = w_in_fetch && r_inflight && !redirect_valid;
  assign w_push_ecall  = w_push && (r_rdata == ECALL);
  assign w_halt_go     = w_pop && (w_head_data == ECALL);
  assign w_redirect_pc = redirect_pc & ALIGN_MASK;
  assign w_rd_idx      = r_pc[AW+1:2];

  // Occupancy counts the slot freed by a same-edge pop so a ready consumer sees one word per cycle.
  assign w_occ   = {1'b0, r_count} + {{(FW+1){1'b0}}, r_inflight} - {{(FW+1){1'b0}}, w_pop};
  assign w_issue = w_in_fetch && !redirect_valid && !r_ecall_stop && !w_push_ecall
                   && (w_occ < (FW+2)'(FIFO_DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_FETCH;
        else       w_state_next = S_IDLE;
      end
      S_FETCH: begin
        if (w_halt_go) w_state_next = S_HALT;
        else           w_state_next = S_FETCH;
      end
      S_HALT: begin
        if (start) w_state_next = S_FETCH;
        else       w_state_next = S_HALT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Instruction memory: loader writes and synchronous fetch reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[load_addr] <= load_data;
    if (w_issue)  r_rdata <= r_mem[w_rd_idx];
  end

  // PC, in-flight read tracking and prefetch FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= {XLEN{1'b0}};
      r_inflight    <= 1'b0;
      r_ecall_stop  <= 1'b0;
      r_halted      <= 1'b0;
      r_wptr        <= {FW{1'b0}};
      r_rptr        <= {FW{1'b0}};
      r_count       <= {(FW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= {XLEN{1'b0}};
        r_fifo_pc[i]   <= {XLEN{1'b0}};
      end
    end else if (w_start) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_ecall_stop <= 1'b0;
      r_halted     <= 1'b0;
      r_wptr       <= {FW{1'b0}};
      r_rptr       <= {FW{1'b0}};
      r_count      <= {(FW+1){1'b0}};
    end else if (r_state == S_IDLE) begin
      if (redirect_valid) r_pc <= w_redirect_pc;
    end else if (w_redirect) begin
      // Redirect beats any same-cycle pop and cancels a pending ECALL.
      r_pc         <= w_redirect_pc;
      r_inflight   <= 1'b0;
      r_ecall_stop <= 1'b0;
      r_wptr       <= {FW{1'b0}};
      r_rptr       <= {FW{1'b0}};
      r_count      <= {(FW+1){1'b0}};
    end else if (w_halt_go) begin
      r_inflight   <= 1'b0;
      r_ecall_stop <= 1'b0;
      r_halted     <= 1'b1;
      r_wptr       <= {FW{1'b0}};
      r_rptr       <= {FW{1'b0}};
      r_count      <= {(FW+1){1'b0}};
    end else if (w_in_fetch) begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight_pc <= r_pc;
      end
      if (w_push) begin
        r_fifo_data[r_wptr] <= r_rdata;
        r_fifo_pc[r_wptr]   <= r_inflight_pc;
        r_wptr              <= r_wptr + FW'(1);
      end
      if (w_pop)        r_rptr       <= r_rptr + FW'(1);
      if (w_push_ecall) r_ecall_stop <= 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + (FW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (FW+1)'(1);
    end
  end

  assign instr_valid      = w_valid;
  assign instruction_word = w_valid ? w_head_data : {XLEN{1'b0}};
  assign instr_pc         = w_valid ? w_head_pc : {XLEN{1'b0}};
  assign Addition_result  = w_valid ? (w_head_pc + PC_STEP) : {XLEN{1'b0}};
  assign halted           = r_halted;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [15:0] r_flush_count;

  // Pop counter wraps; flush counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_count <= 32'd0;
      r_flush_count <= 16'd0;
    end else if (w_start) begin
      r_fetch_count <= 32'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_redirect && (r_flush_count != 16'hFFFF)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (DEPTH=4 so PC wrap is reachable).
// Expected {pc, word} pairs are queued when stimulus is driven and compared on each handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction_word;
  logic [31:0] instr_pc;
  logic [31:0] Addition_result;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] m [4];

  instr_fetch_unit #(.XLEN(32), .DEPTH(4), .FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instruction_word(instruction_word),
    .instr_pc(instr_pc), .Addition_result(Addition_result), .halted(halted)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_load(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 2'(a); load_data = d; m[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] w);
    exp_q.push_back({pc, w});
  endtask

  task automatic test_reset;
    rst = 1'b0; load_en = 1'b0; load_addr = 2'd0; load_data = 32'd0; start = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instruction_word !== 32'd0 || instr_pc !== 32'd0 ||
        Addition_result !== 32'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b w=%h pc=%h add=%h h=%b, expected all zero",
               instr_valid, instruction_word, instr_pc, Addition_result, halted);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL idle_no_fetch: got valid %b, expected 0", instr_valid);
      end
    end
  endtask

  task automatic test_basic_fetch;
    do_load(0, 32'h00800513);
    do_load(1, 32'h00200593);
    do_load(2, 32'h00000073);
    do_load(3, 32'h00300613);
    push_exp(32'h0, m[0]); push_exp(32'h4, m[1]); push_exp(32'h8, m[2]);
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (c < 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++; $display("FAIL basic_latency c=%0d: got valid %b, expected 0", c, instr_valid);
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (instr_valid !== 1'b1) begin
          errors++; $display("FAIL basic_stream c=%0d: got valid %b, expected 1", c, instr_valid);
        end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_extra: got pc %h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instruction_word !== e[31:0] || instr_pc !== e[63:32] || Addition_result !== e[63:32] + 32'd4) begin
            errors++;
            $display("FAIL basic_pop: got w=%h pc=%h add=%h, expected w=%h pc=%h add=%h",
                     instruction_word, instr_pc, Addition_result, e[31:0], e[63:32], e[63:32] + 32'd4);
          end
        end
      end
      if (c == 5) begin
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || instruction_word !== 32'd0) begin
          errors++;
          $display("FAIL basic_halt: got h=%b v=%b w=%h, expected h=1 v=0 w=0", halted, instr_valid, instruction_word);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_drain: got %0d pending, expected 0", exp_q.size());
    end
`ifdef IFU_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++; $display("FAIL perf_fetch_count: got %0d, expected 3", fetch_count);
    end
`endif
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    bit done = 1'b0;
    push_exp(32'h0, m[0]); push_exp(32'h4, m[1]); push_exp(32'h8, m[2]);
    instr_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      instr_ready = (c >= 7);
      if (c >= 2 && c <= 6) begin
        checks++;
        if (instr_valid !== 1'b1 || instruction_word !== 32'h00800513) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got v=%b w=%h, expected v=1 w=00800513", c, instr_valid, instruction_word);
        end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got pc %h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instruction_word !== e[31:0] || instr_pc !== e[63:32]) begin
            errors++;
            $display("FAIL bp_pop: got w=%h pc=%h, expected w=%h pc=%h", instruction_word, instr_pc, e[31:0], e[63:32]);
          end
        end
      end
      if (halted) done = 1'b1;
    end
    checks++;
    if (!done || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_complete: got halted=%b pending=%0d, expected 1 and 0", done, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_redirect;
    do_load(0, 32'h00100093);
    do_load(1, 32'h00208113);
    do_load(2, 32'h00310193);
    do_load(3, 32'h00418213);
    push_exp(32'h0, m[0]);
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 20 && (c < 7 || exp_q.size() != 0); c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (c == 3) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
          errors++; $display("FAIL redir_head: got v=%b pc=%h, expected v=1 pc=4", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000000E;
        push_exp(32'hC, m[3]); push_exp(32'h10, m[0]); push_exp(32'h14, m[1]);
      end
      if (c == 4) redirect_valid = 1'b0;
      if (c == 4 || c == 5) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++; $display("FAIL redir_flush c=%0d: got valid %b, expected 0", c, instr_valid);
        end
      end
      if (c == 6) begin
        checks++;
        if (instr_valid !== 1'b1) begin
          errors++; $display("FAIL redir_latency: got valid %b, expected 1", instr_valid);
        end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL redir_extra: got pc %h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instruction_word !== e[31:0] || instr_pc !== e[63:32] || Addition_result !== e[63:32] + 32'd4) begin
            errors++;
            $display("FAIL redir_pop: got w=%h pc=%h add=%h, expected w=%h pc=%h",
                     instruction_word, instr_pc, Addition_result, e[31:0], e[63:32]);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL redir_timeout: got %0d pending, expected 0", exp_q.size());
    end
`ifdef IFU_PERF_CNT_EN
    checks++;
    if (flush_count !== 16'd1) begin
      errors++; $display("FAIL perf_flush_count: got %0d, expected 1", flush_count);
    end
`endif
    instr_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_wrap;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(32'(4 * i), m[i % 4]);
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (c == 2) begin
        load_en = 1'b1; load_addr = 2'd1; load_data = 32'hDEADBEEF;
      end
      if (c == 3) load_en = 1'b0;
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        e = exp_q.pop_front();
        if (instruction_word !== e[31:0] || instr_pc !== e[63:32]) begin
          errors++;
          $display("FAIL wrap_pop: got w=%h pc=%h, expected w=%h pc=%h", instruction_word, instr_pc, e[31:0], e[63:32]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midrun;
    @(posedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL midrun_streaming: got valid %b, expected 1", instr_valid);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instruction_word !== 32'd0 || halted !== 1'b0 || instr_pc !== 32'd0) begin
      errors++;
      $display("FAIL midrun_async: got v=%b w=%h h=%b pc=%h, expected all zero", instr_valid, instruction_word, halted, instr_pc);
    end
    @(posedge clk); #1 rst = 1'b1;
    push_exp(32'h0, m[0]); push_exp(32'h4, m[1]); push_exp(32'h8, m[2]);
    @(posedge clk); #1;
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b0; redirect_valid = 1'b0;
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        e = exp_q.pop_front();
        if (instruction_word !== e[31:0] || instr_pc !== e[63:32]) begin
          errors++;
          $display("FAIL restart_pop: got w=%h pc=%h, expected w=%h pc=%h", instruction_word, instr_pc, e[31:0], e[63:32]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL restart_timeout: got %0d pending, expected 0", exp_q.size());
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
